// File: rtl/hazard_pkg.sv
// Shared defaults and helpers for the register-hazard tag tracker.
// Optional load-use stall logic is enabled by defining HAZ_LOAD_STALL_EN.
package hazard_pkg;

    localparam int DEF_TAG_W    = 5;
    localparam int DEF_STAGES   = 3;
    localparam int DEF_NUM_SRC  = 2;
    localparam int DEF_ZERO_TAG = 31;

    // Width of a stage index; never narrower than one bit, even for one stage.
    function automatic int sel_w(input int stages);
        return (stages <= 2) ? 1 : $clog2(stages);
    endfunction

endpackage

// File: rtl/hazard_tag_tracker_tag_eq.sv
// Single tag comparator: one instance per (source, stage) pair in the tracker.
module tag_eq #(
    parameter int W = 5
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         eq_o
);

    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/hazard_tag_tracker.sv
// In-flight destination-tag tracker producing hit / forward-select per source.
// Define HAZ_LOAD_STALL_EN to store is_load bits and drive load_stall.
module hazard_tag_tracker
    import hazard_pkg::*;
#(
    parameter int   TAG_W    = DEF_TAG_W,
    parameter int   STAGES   = DEF_STAGES,
    parameter int   NUM_SRC  = DEF_NUM_SRC,
    parameter int   ZERO_TAG = DEF_ZERO_TAG,
    localparam int  SEL_W    = sel_w(STAGES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       advance,
    input  logic                       flush,
    input  logic                       issue_wr,
    input  logic [TAG_W-1:0]           issue_dst,
    input  logic                       issue_is_load,
    input  logic [NUM_SRC*TAG_W-1:0]   src_tag,
    output logic [NUM_SRC-1:0]         src_hit,
    output logic [NUM_SRC*SEL_W-1:0]   src_fwd,
    output logic                       load_stall
);

    localparam logic [TAG_W-1:0] ZERO = TAG_W'(ZERO_TAG);

    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0][TAG_W-1:0]  dst_q,   dst_d;

    always_comb begin
        valid_d = valid_q;
        dst_d   = dst_q;
        if (flush) begin
            valid_d = '0;
        end else if (advance) begin
            for (int i = STAGES - 1; i > 0; i--) begin
                valid_d[i] = valid_q[i-1];
                dst_d[i]   = dst_q[i-1];
            end
            // Writes to the hardwired-zero register are never tracked.
            valid_d[0] = issue_wr && (issue_dst != ZERO);
            dst_d[0]   = issue_dst;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dst_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dst_q   <= dst_d;
        end
    end

`ifdef HAZ_LOAD_STALL_EN
    logic [STAGES-1:0] load_q, load_d;

    always_comb begin
        load_d = load_q;
        if (!flush && advance) begin
            for (int i = STAGES - 1; i > 0; i--) begin
                load_d[i] = load_q[i-1];
            end
            load_d[0] = issue_is_load;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_q <= '0;
        end else begin
            load_q <= load_d;
        end
    end
`endif

    logic [NUM_SRC-1:0][STAGES-1:0] eq;
    logic [NUM_SRC-1:0][STAGES-1:0] live;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            tag_eq #(.W(TAG_W)) u_eq (
                .a_i  (src_tag[k*TAG_W +: TAG_W]),
                .b_i  (dst_q[s]),
                .eq_o (eq[k][s])
            );
        end

        logic [SEL_W-1:0] sel;

        always_comb begin
            live[k] = (src_tag[k*TAG_W +: TAG_W] != ZERO) ? (eq[k] & valid_q) : '0;
            sel     = '0;
            // Scan oldest to youngest so the youngest match overwrites.
            for (int s = STAGES - 1; s >= 0; s--) begin
                if (live[k][s]) begin
                    sel = SEL_W'(s);
                end
            end
        end

        assign src_hit[k]                 = |live[k];
        assign src_fwd[k*SEL_W +: SEL_W]  = sel;
    end

`ifdef HAZ_LOAD_STALL_EN
    always_comb begin
        load_stall = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            // A match at stage 0 is always the youngest match for that source.
            load_stall = load_stall | (live[k][0] & load_q[0]);
        end
    end
`else
    // issue_is_load has no effect in this build.
    assign load_stall = 1'b0 & issue_is_load;
`endif

endmodule

// File: tb/tb_hazard_tag_tracker.sv
// Directed bench for hazard_tag_tracker with a per-cycle reference model.
module tb_hazard_tag_tracker;

    localparam int         TAG_W   = 5;
    localparam int         STAGES  = 3;
    localparam int         NUM_SRC = 2;
    localparam logic [4:0] ZT      = 5'd31;

`ifdef HAZ_LOAD_STALL_EN
    localparam logic EXP_STALL = 1'b1;
`else
    localparam logic EXP_STALL = 1'b0;
`endif

    logic        clk, reset, advance, flush, issue_wr, issue_is_load;
    logic [4:0]  issue_dst;
    logic [9:0]  src_tag;
    logic [1:0]  src_hit;
    logic [3:0]  src_fwd;
    logic        load_stall;

    int checks = 0;
    int errors = 0;

    bit         m_valid [STAGES];
    logic [4:0] m_dst   [STAGES];
    bit         m_load  [STAGES];

    hazard_tag_tracker #(
        .TAG_W(TAG_W), .STAGES(STAGES), .NUM_SRC(NUM_SRC), .ZERO_TAG(31)
    ) dut (
        .clk(clk), .reset(reset), .advance(advance), .flush(flush),
        .issue_wr(issue_wr), .issue_dst(issue_dst), .issue_is_load(issue_is_load),
        .src_tag(src_tag), .src_hit(src_hit), .src_fwd(src_fwd), .load_stall(load_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < STAGES; i++) begin
            m_valid[i] = 1'b0;
            m_dst[i]   = '0;
            m_load[i]  = 1'b0;
        end
    endtask

    // Youngest valid entry holding tag t, ignoring the zero register.
    task automatic model_lookup(input logic [4:0] t, output bit hit, output int idx);
        hit = 1'b0;
        idx = 0;
        if (t != ZT) begin
            for (int s = 0; s < STAGES; s++) begin
                if (!hit && m_valid[s] && m_dst[s] == t) begin
                    hit = 1'b1;
                    idx = s;
                end
            end
        end
    endtask

    task automatic model_outputs(output logic [1:0] h, output logic [3:0] f, output logic st);
        bit hk;
        int ik;
        h  = '0;
        f  = '0;
        st = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            model_lookup(src_tag[k*TAG_W +: TAG_W], hk, ik);
            h[k]         = hk;
            f[k*2 +: 2]  = 2'(ik);
            if (hk && ik == 0 && m_load[0]) st = EXP_STALL;
        end
    endtask

    always @(negedge clk) begin
        logic [1:0] eh;
        logic [3:0] ef;
        logic       es;
        model_outputs(eh, ef, es);
        chk("cyc_hit", 32'(src_hit), 32'(eh));
        chk("cyc_fwd", 32'(src_fwd), 32'(ef));
        chk("cyc_stall", 32'(load_stall), 32'(es));
    end

    task automatic cyc(input logic adv, input logic fl, input logic wr,
                       input logic [4:0] dst, input logic ld);
        advance       = adv;
        flush         = fl;
        issue_wr      = wr;
        issue_dst     = dst;
        issue_is_load = ld;
        @(posedge clk);
        if (!reset) begin
            if (fl) begin
                for (int i = 0; i < STAGES; i++) m_valid[i] = 1'b0;
            end else if (adv) begin
                for (int i = STAGES - 1; i > 0; i--) begin
                    m_valid[i] = m_valid[i-1];
                    m_dst[i]   = m_dst[i-1];
                    m_load[i]  = m_load[i-1];
                end
                m_valid[0] = wr && (dst != ZT);
                m_dst[0]   = dst;
                m_load[0]  = ld;
            end
        end
        #1;
    endtask

    task automatic set_src(input logic [4:0] s0, input logic [4:0] s1);
        src_tag = {s1, s0};
        #1;
    endtask

    initial begin
        reset = 1'b1; advance = 1'b0; flush = 1'b0; issue_wr = 1'b0;
        issue_dst = '0; issue_is_load = 1'b0; src_tag = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hit", 32'(src_hit), 32'h0);
        chk("rst_fwd", 32'(src_fwd), 32'h0);
        chk("rst_stall", 32'(load_stall), 32'h0);
        reset = 1'b0;

        // Single write of tag 3, then read it back from stage 0.
        set_src(5'd3, 5'd0);
        cyc(1, 0, 1, 5'd3, 0);
        chk("one_hit", 32'(src_hit), 32'h1);
        chk("one_fwd", 32'(src_fwd), 32'h0);
        chk("one_stall", 32'(load_stall), 32'h0);

        // Two writers of tag 3: youngest first, then shifted by one.
        cyc(1, 0, 1, 5'd3, 0);
        chk("young_fwd", 32'(src_fwd), 32'h0);
        cyc(1, 0, 0, 5'd0, 0);
        chk("shift_hit", 32'(src_hit), 32'h1);
        chk("shift_fwd", 32'(src_fwd), 32'h1);

        // Zero-register writes and reads never hazard.
        cyc(0, 1, 0, 5'd0, 0);
        set_src(5'd31, 5'd31);
        cyc(1, 0, 1, 5'd31, 0);
        chk("zero_hit_a", 32'(src_hit), 32'h0);
        cyc(1, 0, 1, 5'd31, 0);
        chk("zero_hit_b", 32'(src_hit), 32'h0);
        cyc(0, 0, 0, 5'd0, 0);
        chk("zero_hit_c", 32'(src_hit), 32'h0);

        // Stage contents 7,6,5 held while advance is low, then flush+advance.
        cyc(0, 1, 0, 5'd0, 0);
        cyc(1, 0, 1, 5'd5, 0);
        cyc(1, 0, 1, 5'd6, 0);
        cyc(1, 0, 1, 5'd7, 0);
        set_src(5'd5, 5'd7);
        chk("hold_hit0", 32'(src_hit), 32'h3);
        chk("hold_fwd0", 32'(src_fwd), 32'h2);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 5'd9, 1);
            chk("hold_hit", 32'(src_hit), 32'h3);
            chk("hold_fwd", 32'(src_fwd), 32'h2);
        end
        set_src(5'd6, 5'd6);
        chk("mid_fwd", 32'(src_fwd), 32'h5);
        cyc(1, 1, 1, 5'd5, 0);
        chk("flush_hit", 32'(src_hit), 32'h0);
        chk("flush_fwd", 32'(src_fwd), 32'h0);

        // Load in stage 0 consumed by source 1, then one stage older.
        cyc(1, 0, 1, 5'd9, 1);
        set_src(5'd0, 5'd9);
        chk("lu_hit", 32'(src_hit), 32'h2);
        chk("lu_fwd", 32'(src_fwd), 32'h0);
        chk("lu_stall", 32'(load_stall), 32'(EXP_STALL));
        cyc(1, 0, 0, 5'd0, 0);
        chk("lu2_stall", 32'(load_stall), 32'h0);
        chk("lu2_fwd", 32'(src_fwd), 32'h4);

        // Reset raised between clock edges with three live entries.
        cyc(0, 1, 0, 5'd0, 0);
        cyc(1, 0, 1, 5'd10, 0);
        cyc(1, 0, 1, 5'd11, 0);
        cyc(1, 0, 1, 5'd12, 0);
        set_src(5'd10, 5'd12);
        chk("pre_rst_hit", 32'(src_hit), 32'h3);
        chk("pre_rst_fwd", 32'(src_fwd), 32'h2);
        #1;
        reset = 1'b1;
        model_clear();
        #1;
        chk("async_hit", 32'(src_hit), 32'h0);
        chk("async_fwd", 32'(src_fwd), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(0, 0, 0, 5'd0, 0);
        chk("post_rst_hit", 32'(src_hit), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
